// File: rtl/demux_4_to_16_16width_wr.sv
// -----------------------------------------------------------------------------
// demux_4_to_16_16width_wr
//
// Write-side lane demux. It steers a 16-bit word into one of 16 lanes of a
// registered 256-bit bus. This bus drives the 256-bit input of the lane-select
// read mux in the CPU datapath.
//
// Write modes:
//   - Direct: the accepted word goes to lane s.
//   - Sequential fill: after a seq_start pulse, accepted words fill lanes 0..15
//     in order. A done pulse follows lane 15.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   s            direct-mode lane select (ignored while filling)
//   data_in      word to write
//   in_valid     data_in valid this cycle
//   in_ready     block accepts a word this cycle (low only in DONE)
//   seq_start    one-cycle pulse: start/restart sequential fill at lane 0
//   clr          synchronous clear of bus and valid mask (state/ptr untouched)
//   data_bus_out lane k occupies bits [16k+15:16k]
//   lane_valid   bit k set once lane k written since last reset/clear
//   busy         high while in FILL
//   done         one-cycle pulse after lane 15 is written in FILL
//
// Build option:
//   DEMUX_CLEAR_ON_START_EN - seq_start (in IDLE or FILL) also clears the bus
//                             and valid mask. A word accepted in that same
//                             cycle is still written to lane 0.
// -----------------------------------------------------------------------------
module demux_4_to_16_16width_wr #(
  parameter int LANES = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             s,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   seq_start,
  input  logic                   clr,
  output logic [LANES*WIDTH-1:0] data_bus_out,
  output logic [LANES-1:0]       lane_valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             ptr_q, ptr_d;
  logic [LANES*WIDTH-1:0] bus_d;
  logic [LANES-1:0]       valid_d;
  logic                   accept;
  logic                   wr_en;
  logic [3:0]             wr_lane;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bus_d   = data_bus_out;
    valid_d = lane_valid;
    wr_en   = 1'b0;
    wr_lane = s;
    accept  = in_valid & in_ready;

    unique case (state_q)
      IDLE: begin
        if (seq_start) begin
          state_d = FILL;
          ptr_d   = '0;
          if (accept) begin
            wr_en   = 1'b1;
            wr_lane = '0;
            ptr_d   = 4'd1;
          end
        end else if (accept) begin
          wr_en   = 1'b1;
          wr_lane = s;
        end
      end
      FILL: begin
        if (seq_start) begin
          ptr_d = '0;
          if (accept) begin
            wr_en   = 1'b1;
            wr_lane = '0;
            ptr_d   = 4'd1;
          end
        end else if (accept) begin
          wr_en   = 1'b1;
          wr_lane = ptr_q;
          if (ptr_q == 4'(LANES - 1)) begin
            state_d = DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase

`ifdef DEMUX_CLEAR_ON_START_EN
    if (seq_start && (state_q != DONE)) begin
      bus_d   = '0;
      valid_d = '0;
    end
`endif

    // clr drops the data write only. The FSM and ptr updates above still see
    // the word as accepted.
    if (clr) begin
      bus_d   = '0;
      valid_d = '0;
    end else if (wr_en) begin
      bus_d[wr_lane*WIDTH +: WIDTH] = data_in;
      valid_d[wr_lane]              = 1'b1;
    end
  end

  // Status outputs are registered from the next state. They therefore line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      data_bus_out <= '0;
      lane_valid   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_bus_out <= bus_d;
      lane_valid   <= valid_d;
      busy         <= (state_d == FILL);
      done         <= (state_d == DONE);
      in_ready     <= (state_d != DONE);
    end
  end

endmodule

// File: doc/demux_4_to_16_16width_wr.md
Name: demux_4_to_16_16width_wr

Overview:
- Write-side counterpart of the 16-lane, 16-bit read mux. Steers a 16-bit word into one of 16 lanes of a registered 256-bit bus.
- Two write modes:
  - Direct: lane chosen by a 4-bit select.
  - Sequential fill: lanes 0..15 loaded in order from a valid/ready word stream.
- Sits in front of the lane-select read mux in the CPU datapath. Its data_bus_out feeds that mux's 256-bit data input.

Parameters:
- LANES, 16, number of lanes; fixed at 16; select width is 4.
- WIDTH, 16, bits per lane; bus width = LANES*WIDTH = 256.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s  input  4  direct-mode lane select.
- data_in  input  16  word to write.
- in_valid  input  1  data_in valid this cycle.
- in_ready  output  1  block accepts a word this cycle; a write occurs when in_valid & in_ready.
- seq_start  input  1  one-cycle pulse; begins sequential fill at lane 0.
- clr  input  1  synchronous clear of bus and valid mask.
- data_bus_out  output  256  lane k occupies bits [16k+15:16k].
- lane_valid  output  16  bit k set once lane k has been written since last reset/clear.
- busy  output  1  high while in FILL.
- done  output  1  one-cycle pulse after lane 15 is written in FILL.

Behaviour:
- Reset (rst=1 at edge):
  - data_bus_out=0, lane_valid=0, state=IDLE, ptr=0.
  - busy=0, done=0; in_ready=1 from the next cycle.
  - rst overrides every other input, including mid-FILL: fill abandoned, no done pulse.
- States: IDLE, FILL, DONE. All outputs registered. Write latency 1 cycle: lane visible on data_bus_out the cycle after acceptance.
- in_ready = 1 in IDLE and FILL; 0 in DONE.
- IDLE:
  - Accepted word writes lane s; lane_valid[s] set.
  - seq_start=1: FILL, ptr=0. An accepted word in the same cycle writes lane 0 and sets ptr=1; s is ignored.
- FILL:
  - s ignored.
  - Accepted word writes lane ptr; lane_valid[ptr] set; ptr=ptr+1.
  - in_valid=0 cycles stall with no change.
  - Word accepted at ptr=15: go to DONE; ptr wraps to 0.
  - seq_start in FILL restarts at ptr=0. A same-cycle word goes to lane 0, ptr=1. Already-written lanes keep their data and valid bits.
  - busy=1 throughout FILL.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - No write is possible (in_ready=0).
  - seq_start in DONE is ignored.
- clr:
  - Zeroes data_bus_out and lane_valid.
  - Does not change state or ptr.
  - Priority is rst > clr > write: a write in the same cycle as clr is dropped, but is still counted as accepted, so ptr advances in FILL.
- Only the addressed lane changes on a write; the other 15 lanes hold.
- Rewriting a lane overwrites it; its lane_valid bit stays 1.

Optional Feature:
- Macro: DEMUX_CLEAR_ON_START_EN.
- Defined:
  - Any cycle with seq_start=1 (IDLE or FILL) also zeroes data_bus_out and lane_valid.
  - A word accepted in that cycle is still written to lane 0 and sets lane_valid[0].
- Undefined: seq_start leaves existing lane contents and the valid mask untouched.

Test Plan:
- Direct write: s=4'd5, data_in=16'h7468, in_valid=1 for 1 cycle. Next cycle: data_bus_out[95:80]=16'h7468, lane_valid=16'h0020, all other bits 0.
- Full fill: seq_start pulse, then words 16'h0000..16'h000F on 16 consecutive cycles with in_valid=1.
  - Lane k = k; lane_valid=16'hFFFF.
  - busy high for 16 cycles; done pulse exactly 1 cycle after the 16th word; in_ready=0 that cycle.
- Stalled fill: same stream as the full fill with in_valid=0 on alternate cycles. Same final bus; done arrives 31 cycles after the first word. Bus unchanged on stall cycles.
- Restart: seq_start, 3 words (AAAA, BBBB, CCCC), seq_start again with word DDDD.
  - Lane0=DDDD, lane1=BBBB, lane2=CCCC; next word goes to lane 1.
  - With DEMUX_CLEAR_ON_START_EN defined: lanes 1-2=0 and lane_valid=16'h0001.
- clr/rst: after a full fill, clr=1 for 1 cycle gives bus=0 and lane_valid=0, with state unchanged. rst asserted mid-FILL at ptr=7 gives IDLE, busy=0, no done, and the next direct write to s=3 lands in lane 3.
- Simultaneous clr+write in IDLE: s=2, data_in=16'hFFFF. Result: bus=0, lane_valid=0.
